// File: rtl/npm_toggle_pi_sched_if.sv
// Handshake bundle between the NPM calibration agents, the PI reset engine and the
// round-robin scheduler. The scheduler takes the slave side; the agents and engine take master.
interface npm_toggle_pi_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int TAP_W   = 5
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*TAP_W-1:0] req_tap;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       ack;
  logic [NUM_REQ-1:0]       err;
  logic                     busy;
  logic                     delay_load;
  logic [TAP_W-1:0]         delay_tap;
  logic                     pi_delay_ready;
  logic                     pir_start;
  logic                     pir_ready;
  logic                     pir_last_step;

  modport master (
    output req, req_tap, pi_delay_ready, pir_ready, pir_last_step,
    input  grant, ack, err, busy, delay_load, delay_tap, pir_start
  );

  modport slave (
    input  req, req_tap, pi_delay_ready, pir_ready, pir_last_step,
    output grant, ack, err, busy, delay_load, delay_tap, pir_start
  );
endinterface

// File: rtl/npm_toggle_pi_sched.sv
// Round-robin scheduler sharing one PI reset engine and its delay-tap port among NUM_REQ agents.
// Build macro PI_SCHED_TIMEOUT_EN bounds the DWAIT/START/RUN waits and reports err with ack.
module npm_toggle_pi_sched #(
  parameter int NUM_REQ     = 4,
  parameter int TAP_W       = 5,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                iSystemClock,
  input  logic                iReset,
  npm_toggle_pi_sched_if.slave bus
);
  localparam int               PTR_W       = $clog2(NUM_REQ);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(NUM_REQ - 1);

  typedef enum logic [6:0] {
    S_IDLE   = 7'b0000001,
    S_LOAD   = 7'b0000010,
    S_SETTLE = 7'b0000100,
    S_DWAIT  = 7'b0001000,
    S_START  = 7'b0010000,
    S_RUN    = 7'b0100000,
    S_DONE   = 7'b1000000
  } state_t;

  state_t             state, state_d;
  logic [PTR_W-1:0]   ptr, ptr_d;
  logic [PTR_W-1:0]   owner, owner_d;
  logic [PTR_W-1:0]   win;
  logic [NUM_REQ-1:0] grant, grant_d;
  logic [NUM_REQ-1:0] ack, ack_d;
  logic               busy, busy_d;
  logic               delay_load, delay_load_d;
  logic [TAP_W-1:0]   delay_tap, delay_tap_d;
  logic               pir_start, pir_start_d;
  logic [3:0]         settle_cnt, settle_cnt_d;
  logic               timeout_hit;

  // First requester at or after the pointer, wrapping at NUM_REQ.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [PTR_W-1:0]   start);
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] cand;
    logic             found;
    int               idx;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(start) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PTR_W'(idx);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [TAP_W-1:0] tap_of(input logic [NUM_REQ*TAP_W-1:0] taps,
                                              input logic [PTR_W-1:0]         idx);
    logic [TAP_W-1:0] t;
    t = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == PTR_W'(i)) t = taps[i*TAP_W +: TAP_W];
    end
    return t;
  endfunction

`ifdef PI_SCHED_TIMEOUT_EN
  localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT_CYC - 1);

  logic [9:0]         wait_cnt;
  logic [NUM_REQ-1:0] err, err_d;

  // One counter serves every wait state: it restarts on any state change and saturates.
  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      wait_cnt <= '0;
    end else if (state_d != state) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_LAST) begin
      wait_cnt <= wait_cnt + 10'd1;
    end
  end

  assign timeout_hit = (wait_cnt == WAIT_LAST);

  // DWAIT/START only reach DONE by timing out; RUN does so unless LastStep won.
  always_comb begin
    err_d = '0;
    if (state_d == S_DONE && state != S_DONE && !(state == S_RUN && bus.pir_last_step)) begin
      err_d = grant;
    end
  end

  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) err <= '0;
    else        err <= err_d;
  end

  assign bus.err = err;
`else
  assign timeout_hit = 1'b0;
  assign bus.err     = '0;
`endif

  always_comb begin
    state_d      = state;
    ptr_d        = ptr;
    owner_d      = owner;
    grant_d      = grant;
    ack_d        = '0;
    busy_d       = busy;
    delay_load_d = 1'b0;
    delay_tap_d  = delay_tap;
    pir_start_d  = 1'b0;
    settle_cnt_d = settle_cnt;
    win          = rr_pick(bus.req, ptr);
    case (state)
      S_IDLE: begin
        if (|bus.req) begin
          state_d      = S_LOAD;
          owner_d      = win;
          grant_d      = to_onehot(win);
          delay_tap_d  = tap_of(bus.req_tap, win);
          busy_d       = 1'b1;
          delay_load_d = 1'b1;
        end
      end
      S_LOAD: begin
        state_d      = S_SETTLE;
        settle_cnt_d = '0;
      end
      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_d = S_DWAIT;
        else                           settle_cnt_d = settle_cnt + 4'd1;
      end
      S_DWAIT: begin
        if (bus.pi_delay_ready) begin
          state_d = S_START;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          ack_d   = grant;
        end
      end
      S_START: begin
        if (bus.pir_ready) begin
          state_d     = S_RUN;
          pir_start_d = 1'b1;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          ack_d   = grant;
        end
      end
      S_RUN: begin
        if (bus.pir_last_step || timeout_hit) begin
          state_d = S_DONE;
          ack_d   = grant;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = (owner == PTR_LAST) ? '0 : owner + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      owner      <= '0;
      grant      <= '0;
      ack        <= '0;
      busy       <= 1'b0;
      delay_load <= 1'b0;
      delay_tap  <= '0;
      pir_start  <= 1'b0;
      settle_cnt <= '0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      owner      <= owner_d;
      grant      <= grant_d;
      ack        <= ack_d;
      busy       <= busy_d;
      delay_load <= delay_load_d;
      delay_tap  <= delay_tap_d;
      pir_start  <= pir_start_d;
      settle_cnt <= settle_cnt_d;
    end
  end

  assign bus.grant      = grant;
  assign bus.ack        = ack;
  assign bus.busy       = busy;
  assign bus.delay_load = delay_load;
  assign bus.delay_tap  = delay_tap;
  assign bus.pir_start  = pir_start;
endmodule

// File: tb/tb_npm_toggle_pi_sched.sv
// Scoreboard bench for npm_toggle_pi_sched: directed sequences push expected load/start/ack
// events; a monitor pops and compares them whenever the scheduler presents one.
`timescale 1ns/1ps
module tb_npm_toggle_pi_sched;
  localparam int NUM_REQ    = 4;
  localparam int TAP_W      = 5;
  localparam int SETTLE_CYC = 4;
`ifdef PI_SCHED_TIMEOUT_EN
  localparam int TIMEOUT_CYC = 50;
`else
  localparam int TIMEOUT_CYC = 1023;
`endif
  localparam int K_LOAD  = 0;
  localparam int K_START = 1;
  localparam int K_ACK   = 2;

  typedef struct {
    int kind;
    int vec;
    int err;
    int tap;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  npm_toggle_pi_sched_if #(.NUM_REQ(NUM_REQ), .TAP_W(TAP_W)) bus ();

  npm_toggle_pi_sched #(
    .NUM_REQ(NUM_REQ), .TAP_W(TAP_W), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .iSystemClock(clk),
    .iReset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_expired(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  task automatic push(input int kind, input int vec, input int err, input int tap, input int c);
    exp_t e;
    e.kind = kind; e.vec = vec; e.err = err; e.tap = tap; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic mon_event(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, required no event", kind, cyc);
      return;
    end
    e = sb.pop_front();
    check("event_kind", kind, e.kind);
    if (kind != e.kind) return;
    if (e.cyc >= 0) check("event_cycle", cyc, e.cyc);
    case (kind)
      K_LOAD: begin
        check("load_grant", int'(bus.grant), e.vec);
        check("load_tap", int'(bus.delay_tap), e.tap);
        check("load_busy", int'(bus.busy), 1);
      end
      K_START: begin
        check("start_grant", int'(bus.grant), e.vec);
        check("start_tap", int'(bus.delay_tap), e.tap);
      end
      default: begin
        check("ack_vec", int'(bus.ack), e.vec);
        check("ack_err", int'(bus.err), e.err);
        check("ack_grant", int'(bus.grant), e.vec);
        check("ack_busy", int'(bus.busy), 1);
      end
    endcase
  endtask

  // Monitor samples 1 ns after each rising edge.
  always @(posedge clk) begin
    #1;
    if (bus.delay_load === 1'b1) mon_event(K_LOAD);
    if (bus.pir_start === 1'b1)  mon_event(K_START);
    if (|bus.ack)                mon_event(K_ACK);
    if (|bus.err && !(|bus.ack)) check("err_without_ack", int'(bus.err), 0);
  end

  task automatic wait_cyc(input int target);
    int g = 0;
    while (cyc < target && g < 5000) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic wait_start();
    int g = 0;
    while (bus.pir_start !== 1'b1 && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (bus.pir_start !== 1'b1) bound_expired("wait_pir_start");
  endtask

  task automatic pulse_last();
    bus.pir_last_step = 1'b1;
    @(negedge clk);
    bus.pir_last_step = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int d;
    rst                = 1'b1;
    bus.req            = '0;
    bus.req_tap        = {5'd30, 5'd9, 5'd17, 5'd5};
    bus.pi_delay_ready = 1'b1;
    bus.pir_ready      = 1'b1;
    bus.pir_last_step  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", int'(bus.grant), 0);
    check("rst_ack", int'(bus.ack), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_delay_load", int'(bus.delay_load), 0);
    check("rst_delay_tap", int'(bus.delay_tap), 0);
    check("rst_pir_start", int'(bus.pir_start), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Contention from pointer 0: 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      push(K_LOAD, 1 << (i % 4), 0, (i % 4 == 0) ? 5 : (i % 4 == 1) ? 17 : (i % 4 == 2) ? 9 : 30, -1);
      push(K_START, 1 << (i % 4), 0, (i % 4 == 0) ? 5 : (i % 4 == 1) ? 17 : (i % 4 == 2) ? 9 : 30, -1);
      push(K_ACK, 1 << (i % 4), 0, 0, -1);
    end
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_start();
      pulse_last();
    end
    bus.req = '0;
    repeat (3) @(negedge clk);

    // Single request, nominal latency, tap change after grant ignored
    d = cyc;
    push(K_LOAD, 4'b0010, 0, 17, d + 1);
    push(K_START, 4'b0010, 0, 17, d + 8);
    bus.req = 4'b0010;
    @(negedge clk);
    bus.req_tap[1*TAP_W +: TAP_W] = 5'd3;
    wait_start();
    push(K_ACK, 4'b0010, 0, 0, cyc + 1);
    pulse_last();
    bus.req = '0;
    bus.req_tap[1*TAP_W +: TAP_W] = 5'd17;
    repeat (2) @(negedge clk);

    // Engine busy for 30 START cycles; LastStep during START ignored
    bus.pir_ready = 1'b0;
    d = cyc;
    push(K_LOAD, 4'b1000, 0, 30, d + 1);
    push(K_START, 4'b1000, 0, 30, d + 37);
    bus.req = 4'b1000;
    wait_cyc(d + 10);
    pulse_last();
    wait_cyc(d + 36);
    bus.pir_ready = 1'b1;
    wait_start();
    push(K_ACK, 4'b1000, 0, 0, cyc + 1);
    pulse_last();
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Delay ready high through SETTLE, then low 20 cycles in DWAIT
    d = cyc;
    push(K_LOAD, 4'b0001, 0, 5, d + 1);
    push(K_START, 4'b0001, 0, 5, d + 28);
    bus.req = 4'b0001;
    wait_cyc(d + 6);
    bus.pi_delay_ready = 1'b0;
    wait_cyc(d + 15);
    pulse_last();
    wait_cyc(d + 26);
    bus.pi_delay_ready = 1'b1;
    wait_start();
    push(K_ACK, 4'b0001, 0, 0, cyc + 1);
    pulse_last();
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Reset during RUN: no ack, outputs cleared, pointer back to 0
    d = cyc;
    push(K_LOAD, 4'b0010, 0, 17, d + 1);
    push(K_START, 4'b0010, 0, 17, d + 8);
    bus.req = 4'b0010;
    wait_start();
    @(negedge clk);
    rst     = 1'b1;
    bus.req = '0;
    @(negedge clk);
    check("midrst_grant", int'(bus.grant), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_ack", int'(bus.ack), 0);
    check("midrst_pir_start", int'(bus.pir_start), 0);
    check("midrst_delay_tap", int'(bus.delay_tap), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    d = cyc;
    push(K_LOAD, 4'b0001, 0, 5, d + 1);
    push(K_START, 4'b0001, 0, 5, d + 8);
    push(K_ACK, 4'b0001, 0, 0, -1);
    bus.req = 4'b1111;
    wait_start();
    pulse_last();
    bus.req = '0;
    repeat (2) @(negedge clk);

    d = cyc;
    push(K_LOAD, 4'b0100, 0, 9, d + 1);
    push(K_START, 4'b0100, 0, 9, d + 8);
    push(K_ACK, 4'b0100, 0, 0, -1);
    bus.req = 4'b0100;
    wait_start();
    pulse_last();
    bus.req = '0;
    repeat (2) @(negedge clk);

`ifdef PI_SCHED_TIMEOUT_EN
    // Delay ready stuck low: owner 0 (pointer at 3) times out, then requester 1 is served
    bus.pi_delay_ready = 1'b0;
    d = cyc;
    push(K_LOAD, 4'b0001, 0, 5, d + 1);
    push(K_ACK, 4'b0001, 4'b0001, 0, d + 56);
    push(K_LOAD, 4'b0010, 0, 17, -1);
    push(K_START, 4'b0010, 0, 17, -1);
    push(K_ACK, 4'b0010, 0, 0, -1);
    bus.req = 4'b0011;
    wait_cyc(d + 56);
    bus.req            = 4'b0010;
    bus.pi_delay_ready = 1'b1;
    wait_start();
    pulse_last();
    bus.req = '0;
    repeat (2) @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
